// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
//   state_e           : controller FSM states (IDLE / BUSY / DONE)
//   DefTimeoutCycles  : default BUSY cycles without MemAck before an abort
//   DefErrData        : default ReadDataM value after a timed-out read
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DefTimeoutCycles = 15;
  localparam logic [31:0] DefErrData       = 32'hDEADBEEF;

endpackage

// File: rtl/mem_access_controller_if.sv
// Bus bundle between the MEM pipeline stage, the access controller and data memory.
//   Pipeline side : MemReadM, MemWriteM, ALUResultM, WriteDataM (in), StallM, FlushW,
//                   ReadDataM, MemErr (out)
//   Memory side   : MemReq, MemWe, MemAddr, MemWData (out), MemAck, MemRData (in)
// modport master : the controller; modport slave : pipeline + memory environment.
interface mem_access_controller_if;

  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic        FlushW;
  logic [31:0] ReadDataM;
  logic        MemErr;

  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemAck;
  logic [31:0] MemRData;

  modport master (
    input  MemReadM, MemWriteM, ALUResultM, WriteDataM, MemAck, MemRData,
    output StallM, FlushW, ReadDataM, MemErr, MemReq, MemWe, MemAddr, MemWData
  );

  modport slave (
    output MemReadM, MemWriteM, ALUResultM, WriteDataM, MemAck, MemRData,
    input  StallM, FlushW, ReadDataM, MemErr, MemReq, MemWe, MemAddr, MemWData
  );

endinterface

// File: rtl/mem_timeout_counter.sv
// 8-bit BUSY-cycle counter used to abort memory accesses that are never acknowledged.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : restart the count (entry to BUSY)
//   enable_i      : one more BUSY cycle without MemAck
//   expired_o     : this enabled cycle is the Timeout-th one; the access must abort now
module mem_timeout_counter #(
  parameter int unsigned Timeout = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the cycle whose increment would make the count reach Timeout.
  assign expired_o = enable_i & (cnt_q == 8'(Timeout - 1));

endmodule

// File: rtl/mem_access_controller.sv
// MEM-stage data-memory access controller. Stalls the pipeline while a load/store is
// outstanding, bubbles MEM/WB meanwhile, and registers load data for write-back.
//   Clk, Rst : clock, asynchronous active-low reset
//   bus_io   : mem_access_controller_if.master (pipeline and memory handshake)
// Optional feature: define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES BUSY
// cycles without MemAck (sticky MemErr, ERR_DATA returned for reads). Without it, BUSY
// waits forever and MemErr is tied to 0.
module mem_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter logic [31:0] ERR_DATA       = DefErrData
) (
  input logic                     Clk,
  input logic                     Rst,
  mem_access_controller_if.master bus_io
);

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        access, is_read, mem_req, ack, timeout;

  assign access  = bus_io.MemReadM | bus_io.MemWriteM;
  // Read+write together is treated as a store.
  assign is_read = bus_io.MemReadM & ~bus_io.MemWriteM;
  // Gated by Rst so the request drops the instant reset asserts, even with Access held.
  assign mem_req = Rst & (((state_q == IDLE) & access) | (state_q == BUSY));
  assign ack     = mem_req & bus_io.MemAck;

`ifdef MEM_TIMEOUT_EN
  logic busy_entry, busy_wait, err_q, err_d;

  assign busy_entry = (state_q == IDLE) & access & ~bus_io.MemAck;
  assign busy_wait  = (state_q == BUSY) & ~bus_io.MemAck;

  mem_timeout_counter #(
    .Timeout(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (Clk),
    .rst_ni   (Rst),
    .clear_i  (busy_entry),
    .enable_i (busy_wait),
    .expired_o(timeout)
  );

  assign err_d = err_q | timeout;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus_io.MemErr = err_q;
`else
  assign timeout       = 1'b0;
  assign bus_io.MemErr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE:    if (access) state_d = bus_io.MemAck ? DONE : BUSY;
      BUSY:    if (bus_io.MemAck || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // timeout is only ever raised in BUSY without MemAck, so an ack always wins.
    if (ack && is_read) begin
      rdata_d = bus_io.MemRData;
    end else if (timeout && is_read) begin
      rdata_d = ERR_DATA;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_io.MemReq    = mem_req;
  assign bus_io.MemWe     = bus_io.MemWriteM;
  assign bus_io.MemAddr   = bus_io.ALUResultM;
  assign bus_io.MemWData  = bus_io.WriteDataM;
  assign bus_io.StallM    = mem_req;
  assign bus_io.FlushW    = mem_req;
  assign bus_io.ReadDataM = rdata_q;

endmodule
